// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// the RISC-V NOP used to scrub instruction memory, and default parameters.
package program_loader_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam int unsigned IMEM_DEPTH_DEFAULT = 256;
  localparam int unsigned TIMEOUT_DEFAULT    = 1000;
  localparam int unsigned STABLE_CYC_DEFAULT = 4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_TOUT
  } state_t;

endpackage

// File: rtl/pc_stall_detector.sv
// Flags a CPU that has parked on one fetch address: asserts when the same
// cpu_pc has been observed for STABLE_CYC consecutive enabled cycles.
module pc_stall_detector
  import program_loader_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned STABLE_CYC = STABLE_CYC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [XLEN-1:0] cpu_pc,
  output logic            stalled_c
);

  localparam int unsigned CW = $clog2(STABLE_CYC + 1);

  logic [XLEN-1:0] prev_pc;
  logic [CW-1:0]   run_len;
  logic [CW-1:0]   run_next;

  // run_len counts cycles the current pc has been seen, including this one
  always_comb begin
    run_next  = CW'(1);
    stalled_c = 1'b0;
    if ((run_len != '0) && (cpu_pc == prev_pc)) begin
      run_next = (run_len == CW'(STABLE_CYC)) ? run_len : run_len + CW'(1);
    end
    stalled_c = en && (run_next == CW'(STABLE_CYC));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pc <= '0;
      run_len <= '0;
    end else if (en) begin
      prev_pc <= cpu_pc;
      run_len <= run_next;
    end else begin
      run_len <= '0;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Scrubs instruction memory with NOPs, streams a program into it, then
// releases the CPU and watches for a halt or a watchdog expiry.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int unsigned STABLE_CYC = STABLE_CYC_DEFAULT,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            cpu_reset,
  input  logic [XLEN-1:0] cpu_pc,
  input  logic [XLEN-1:0] halt_pc,
  output logic            done,
  output logic            timeout,
  output logic            overflow,
  output logic [AW:0]     words_loaded,
  output logic [31:0]     cycle_count
);

  localparam int unsigned WW = AW + 1;
  localparam int unsigned CCW = 32;

  state_t         state, state_d;
  logic [AW-1:0]  clr_addr, clr_addr_d;
  logic [WW-1:0]  words_d;
  logic [CCW-1:0] cycles_d;
  logic           done_d, timeout_d, overflow_d;
  logic           running_c, stalled_c, halt_c;

  pc_stall_detector #(
    .XLEN       (XLEN),
    .STABLE_CYC (STABLE_CYC)
  ) u_stall (
    .clk       (clk),
    .reset     (reset),
    .en        (running_c),
    .cpu_pc    (cpu_pc),
    .stalled_c (stalled_c)
  );

  assign halt_c = (cpu_pc == halt_pc) || stalled_c;

  always_comb begin
    state_d    = state;
    clr_addr_d = clr_addr;
    words_d    = words_loaded;
    cycles_d   = cycle_count;
    done_d     = done;
    timeout_d  = timeout;
    overflow_d = overflow;
    ld_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    cpu_reset  = 1'b1;
    running_c  = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_TOUT: begin
        if (start) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
          words_d    = '0;
          cycles_d   = '0;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end
      S_CLEAR: begin
        imem_we    = 1'b1;
        imem_addr  = clr_addr;
        imem_wdata = XLEN'(NOP_INSN);
        clr_addr_d = clr_addr + AW'(1);
        if (clr_addr == AW'(IMEM_DEPTH - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_ready   = 1'b1;
        imem_addr  = words_loaded[AW-1:0];
        imem_wdata = ld_data;
        if (ld_valid) begin
          // a word beyond capacity is dropped and ends the session
          if (words_loaded == WW'(IMEM_DEPTH)) begin
            overflow_d = 1'b1;
            timeout_d  = 1'b1;
            state_d    = S_TOUT;
          end else begin
            imem_we = 1'b1;
            words_d = words_loaded + WW'(1);
            if (ld_last) state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        running_c = 1'b1;
        // halt is checked first so it wins over a simultaneous timeout
        if (halt_c) begin
          cycles_d = cycle_count + CCW'(1);
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (cycle_count == CCW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_TOUT;
        end else begin
          cycles_d = cycle_count + CCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      clr_addr     <= '0;
      words_loaded <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_d;
      clr_addr     <= clr_addr_d;
      words_loaded <= words_d;
      cycle_count  <= cycles_d;
      done         <= done_d;
      timeout      <= timeout_d;
      overflow     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: two instances (depth 8 and depth 4)
// with a write scoreboard per instance and a tiny CPU pc model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        ld_valid, ld_last;
  logic [31:0] ld_data;
  logic [31:0] cpu_pc = '0;
  logic [31:0] halt_pc;
  bit          pc_step;

  logic        a_ld_ready, a_imem_we, a_cpu_reset, a_done, a_timeout, a_overflow;
  logic [2:0]  a_imem_addr;
  logic [31:0] a_imem_wdata, a_cycle_count;
  logic [3:0]  a_words_loaded;

  logic        b_ld_ready, b_imem_we, b_cpu_reset, b_done, b_timeout, b_overflow;
  logic [1:0]  b_imem_addr;
  logic [31:0] b_imem_wdata, b_cycle_count;
  logic [2:0]  b_words_loaded;

  logic [39:0] q_a[$];
  logic [39:0] q_b[$];
  logic [39:0] exp_a, exp_b;
  logic [31:0] prog [0:7];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_loader #(.XLEN(32), .IMEM_DEPTH(8), .TIMEOUT(20), .STABLE_CYC(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .ld_valid(ld_valid), .ld_ready(a_ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .imem_we(a_imem_we), .imem_addr(a_imem_addr),
    .imem_wdata(a_imem_wdata), .cpu_reset(a_cpu_reset), .cpu_pc(cpu_pc), .halt_pc(halt_pc),
    .done(a_done), .timeout(a_timeout), .overflow(a_overflow),
    .words_loaded(a_words_loaded), .cycle_count(a_cycle_count)
  );

  program_loader #(.XLEN(32), .IMEM_DEPTH(4), .TIMEOUT(20), .STABLE_CYC(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ld_valid(ld_valid), .ld_ready(b_ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
    .imem_wdata(b_imem_wdata), .cpu_reset(b_cpu_reset), .cpu_pc(cpu_pc), .halt_pc(halt_pc),
    .done(b_done), .timeout(b_timeout), .overflow(b_overflow),
    .words_loaded(b_words_loaded), .cycle_count(b_cycle_count)
  );

  // CPU stand-in: fetch pc held at 0 in reset, then steps by 4 or parks
  always @(posedge clk) begin
    if (a_cpu_reset) cpu_pc <= '0;
    else if (pc_step) cpu_pc <= cpu_pc + 32'd4;
  end

  // write scoreboards
  always @(negedge clk) begin
    if (a_imem_we === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_write unexpected addr=%0d data=%h", a_imem_addr, a_imem_wdata);
      end else begin
        exp_a = q_a.pop_front();
        if ({8'(a_imem_addr), a_imem_wdata} !== exp_a) begin
          errors++;
          $display("FAIL a_write got addr=%0d data=%h want addr=%0d data=%h",
                   a_imem_addr, a_imem_wdata, exp_a[39:32], exp_a[31:0]);
        end
      end
    end
    if (b_imem_we === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_write unexpected addr=%0d data=%h", b_imem_addr, b_imem_wdata);
      end else begin
        exp_b = q_b.pop_front();
        if ({8'(b_imem_addr), b_imem_wdata} !== exp_b) begin
          errors++;
          $display("FAIL b_write got addr=%0d data=%h want addr=%0d data=%h",
                   b_imem_addr, b_imem_wdata, exp_b[39:32], exp_b[31:0]);
        end
      end
    end
  end

  task automatic push_exp(input bit sel, input int addr, input logic [31:0] data);
    if (sel) q_b.push_back({8'(addr), data});
    else     q_a.push_back({8'(addr), data});
  endtask

  task automatic pulse_start(input bit sel, input int depth);
    @(posedge clk) #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    for (int i = 0; i < depth; i++) push_exp(sel, i, 32'h0000_0013);
    @(posedge clk) #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_ready(input bit sel);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((sel ? b_ld_ready : a_ld_ready) === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_ready sel=%0d ld_ready never rose within 40 cycles", sel);
  endtask

  task automatic wait_end(input bit sel);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel ? (b_done | b_timeout) : (a_done | a_timeout)) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_end sel=%0d no done/timeout within 100 cycles", sel);
  endtask

  // drive n words from prog[base..]; gap inserts an idle cycle between words
  task automatic send_words(input bit sel, input int base, input int n, input bit last,
                            input bit gap, input int depth);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        @(posedge clk) #1;
        ld_valid = 1'b0;
        ld_last  = 1'b1;
        ld_data  = $urandom;
      end
      @(posedge clk) #1;
      ld_valid = 1'b1;
      ld_data  = prog[base + i];
      ld_last  = last && (i == n - 1);
      if (i < depth) push_exp(sel, i, prog[base + i]);
    end
    @(posedge clk) #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    checks++; if (a_cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b want 1", a_cpu_reset); end
    checks++; if (a_ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got %b want 0", a_ld_ready); end
    checks++; if (a_imem_we !== 1'b0) begin errors++; $display("FAIL rst_imem_we got %b want 0", a_imem_we); end
    checks++; if ({a_done, a_timeout, a_overflow} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {a_done, a_timeout, a_overflow}); end
    checks++; if (a_words_loaded !== 4'd0) begin errors++; $display("FAIL rst_words got %0d want 0", a_words_loaded); end
    checks++; if (a_cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycles got %0d want 0", a_cycle_count); end
    checks++; if (b_cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_b_cpu_reset got %b want 1", b_cpu_reset); end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_cpu_reset !== 1'b1 || a_ld_ready !== 1'b0) begin errors++; $display("FAIL idle_outputs got cpu_reset=%b ld_ready=%b want 1/0", a_cpu_reset, a_ld_ready); end
  endtask

  task automatic test_program_run;
    pc_step = 1'b1;
    halt_pc = 32'h14;
    pulse_start(1'b0, 8);
    wait_ready(1'b0);
    send_words(1'b0, 0, 5, 1'b1, 1'b0, 8);
    wait_end(1'b0);
    checks++; if (a_done !== 1'b1 || a_timeout !== 1'b0) begin errors++; $display("FAIL prog_done got done=%b timeout=%b want 1/0", a_done, a_timeout); end
    checks++; if (a_words_loaded !== 4'd5) begin errors++; $display("FAIL prog_words got %0d want 5", a_words_loaded); end
    checks++; if (a_cycle_count !== 32'd6) begin errors++; $display("FAIL prog_cycles got %0d want 6", a_cycle_count); end
    checks++; if (a_cpu_reset !== 1'b1) begin errors++; $display("FAIL prog_cpu_reset got %b want 1", a_cpu_reset); end
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL prog_pending got %0d want 0", q_a.size()); end
  endtask

  task automatic test_handshake;
    pc_step = 1'b1;
    halt_pc = 32'h8;
    pulse_start(1'b0, 8);
    checks++; if (a_done !== 1'b0 || a_words_loaded !== 4'd0) begin errors++; $display("FAIL restart_clear got done=%b words=%0d want 0/0", a_done, a_words_loaded); end
    wait_ready(1'b0);
    send_words(1'b0, 0, 4, 1'b1, 1'b1, 8);
    wait_end(1'b0);
    checks++; if (a_done !== 1'b1 || a_words_loaded !== 4'd4) begin errors++; $display("FAIL hs_result got done=%b words=%0d want 1/4", a_done, a_words_loaded); end
    checks++; if (a_cycle_count !== 32'd3) begin errors++; $display("FAIL hs_cycles got %0d want 3", a_cycle_count); end
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL hs_pending got %0d want 0", q_a.size()); end
  endtask

  task automatic test_reset_mid_load;
    pulse_start(1'b0, 8);
    wait_ready(1'b0);
    send_words(1'b0, 0, 3, 1'b0, 1'b0, 8);
    @(negedge clk);
    checks++; if (a_words_loaded !== 4'd3) begin errors++; $display("FAIL midload_words got %0d want 3", a_words_loaded); end
    #1 reset = 1'b0;
    #1;
    checks++; if (a_cpu_reset !== 1'b1 || a_ld_ready !== 1'b0) begin errors++; $display("FAIL midrst_outputs got cpu_reset=%b ld_ready=%b want 1/0", a_cpu_reset, a_ld_ready); end
    checks++; if (a_words_loaded !== 4'd0) begin errors++; $display("FAIL midrst_words got %0d want 0", a_words_loaded); end
    @(negedge clk);
    reset = 1'b1;
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL midrst_pending got %0d want 0", q_a.size()); end
  endtask

  task automatic test_stall;
    pc_step = 1'b0;
    halt_pc = 32'h100;
    pulse_start(1'b0, 8);
    wait_ready(1'b0);
    send_words(1'b0, 5, 1, 1'b1, 1'b0, 8);
    wait_end(1'b0);
    checks++; if (a_done !== 1'b1 || a_timeout !== 1'b0) begin errors++; $display("FAIL stall_done got done=%b timeout=%b want 1/0", a_done, a_timeout); end
    checks++; if (a_cycle_count == 32'd0 || a_cycle_count > 32'd4) begin errors++; $display("FAIL stall_cycles got %0d want 1..4", a_cycle_count); end
  endtask

  task automatic test_timeout;
    pc_step = 1'b1;
    halt_pc = 32'hFFFF_FFFC;
    pulse_start(1'b0, 8);
    wait_ready(1'b0);
    send_words(1'b0, 0, 2, 1'b1, 1'b0, 8);
    start_a = 1'b1;
    @(posedge clk) #1;
    start_a = 1'b0;
    wait_end(1'b0);
    checks++; if (a_timeout !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL tout_flags got timeout=%b done=%b want 1/0", a_timeout, a_done); end
    checks++; if (a_cycle_count !== 32'd19) begin errors++; $display("FAIL tout_cycles got %0d want 19", a_cycle_count); end
    checks++; if (a_cpu_reset !== 1'b1 || a_overflow !== 1'b0) begin errors++; $display("FAIL tout_state got cpu_reset=%b overflow=%b want 1/0", a_cpu_reset, a_overflow); end
    repeat (3) @(negedge clk);
    checks++; if (a_cycle_count !== 32'd19) begin errors++; $display("FAIL tout_frozen got %0d want 19", a_cycle_count); end
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL tout_pending got %0d want 0", q_a.size()); end
  endtask

  task automatic test_overflow;
    pulse_start(1'b1, 4);
    wait_ready(1'b1);
    send_words(1'b1, 0, 5, 1'b0, 1'b0, 4);
    wait_end(1'b1);
    checks++; if (b_overflow !== 1'b1 || b_timeout !== 1'b1 || b_done !== 1'b0) begin errors++; $display("FAIL ovf_flags got ovf=%b tout=%b done=%b want 1/1/0", b_overflow, b_timeout, b_done); end
    checks++; if (b_words_loaded !== 3'd4) begin errors++; $display("FAIL ovf_words got %0d want 4", b_words_loaded); end
    checks++; if (b_ld_ready !== 1'b0) begin errors++; $display("FAIL ovf_ld_ready got %b want 0", b_ld_ready); end
    checks++; if (q_b.size() != 0) begin errors++; $display("FAIL ovf_pending got %0d want 0", q_b.size()); end
  endtask

  initial begin
    start_a  = 1'b0;
    start_b  = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;
    halt_pc  = 32'hFFFF_FFFC;
    pc_step  = 1'b1;
    prog[0] = 32'h0010_0093;  // addi x1,x0,1
    prog[1] = 32'h0020_0113;  // addi x2,x0,2
    prog[2] = 32'h0020_81B3;  // add  x3,x1,x2
    prog[3] = 32'h0031_8463;  // beq  x3,x3,8
    prog[4] = 32'h0080_006F;  // jal  x0,8
    prog[5] = 32'h0000_006F;  // jal  x0,0
    prog[6] = 32'hDEAD_BEEF;
    prog[7] = 32'h1234_5678;

    test_reset();
    test_program_run();
    test_handshake();
    test_reset_mid_load();
    test_stall();
    test_timeout();
    test_overflow();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter XLEN, 32, instruction/data word width in bits.
REQ-002 Parameter IMEM_DEPTH, 256, instruction-memory words; must be a power of two; AW = log2(IMEM_DEPTH).
REQ-003 Parameter TIMEOUT, 1000, maximum RUN cycles before the watchdog fires.
REQ-004 Parameter STABLE_CYC, 4, consecutive cycles of unchanged cpu_pc that count as a halt.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a load/run session when in IDLE.
REQ-008 ld_valid  in  1  load word available.
REQ-009 ld_ready  out  1  loader accepts a word this cycle.
REQ-010 ld_data  in  XLEN  instruction word.
REQ-011 ld_last  in  1  marks the final word of the program.
REQ-012 imem_we  out  1  instruction-memory write strobe.
REQ-013 imem_addr  out  AW  word address.
REQ-014 imem_wdata  out  XLEN  write data.
REQ-015 cpu_reset  out  1  active-high reset driven to the CPU.
REQ-016 cpu_pc  in  XLEN  CPU fetch PC (byte address).
REQ-017 halt_pc  in  XLEN  byte address treated as end of program.
REQ-018 done  out  1  session ended by halt.
REQ-019 timeout  out  1  session ended by watchdog.
REQ-020 overflow  out  1  program exceeded IMEM_DEPTH words.
REQ-021 words_loaded  out  AW+1  words written this session.
REQ-022 cycle_count  out  32  CPU cycles spent in RUN.

Function
REQ-023 FSM states: IDLE, CLEAR, LOAD, RUN, DONE, TOUT; encoding is free.
REQ-024 IDLE: ld_ready=0, cpu_reset=1; on start go to CLEAR and zero words_loaded, cycle_count, done, timeout and overflow.
REQ-025 CLEAR: write 32'h00000013 (NOP) to addresses 0..IMEM_DEPTH-1, one per cycle; go to LOAD after the last address, so CLEAR lasts exactly IMEM_DEPTH cycles.
REQ-026 LOAD: ld_ready=1; a transfer occurs when ld_valid and ld_ready are both high; write the word combinationally in the same cycle at imem_addr=words_loaded[AW-1:0]; increment words_loaded.
REQ-027 A transfer with ld_last=1 moves the FSM to RUN on the next edge.
REQ-028 A transfer when words_loaded==IMEM_DEPTH is dropped (no write), sets overflow, and moves the FSM to TOUT.
REQ-029 RUN: cpu_reset=0; cycle_count increments every cycle.
REQ-030 RUN exits to DONE when cpu_pc==halt_pc, or when cpu_pc is unchanged for STABLE_CYC consecutive cycles.
REQ-031 RUN exits to TOUT when cycle_count reaches TIMEOUT-1 without a halt; if a halt and the timeout occur in the same cycle, halt wins.
REQ-032 DONE/TOUT: cpu_reset=1; done/timeout held at 1; cycle_count frozen; start returns to CLEAR.
REQ-033 start outside IDLE/DONE/TOUT is ignored.
REQ-034 imem_we is 0 in every state except CLEAR and accepted LOAD transfers.

Reset
REQ-035 reset low asynchronously forces IDLE, cpu_reset=1, ld_ready=0, imem_we=0, and all flags and counters to 0; an in-flight load is abandoned.

Structure
REQ-036 A shared package holds the FSM state typedef, the NOP constant, and the default parameter values.
REQ-037 One sub-module, pc_stall_detector (cpu_pc history plus the STABLE_CYC counter), is instantiated; everything else lives in program_loader.

Verification
REQ-038 Reset mid-LOAD after 3 words -> IDLE, cpu_reset=1, words_loaded=0.
REQ-039 Load 5 words (addi/addi/add/beq/jal), halt_pc=0x14, IMEM_DEPTH=8 -> 8 NOP writes, then words at addresses 0..4, RUN, done=1, words_loaded=5.
REQ-040 ld_valid toggling every other cycle -> writes occur only on handshake cycles, and addresses are contiguous.
REQ-041 IMEM_DEPTH=4, 5 words without ld_last -> 4 writes, overflow=1, timeout=1.
REQ-042 Program "jal x0,0" with halt_pc unreachable and STABLE_CYC=4 -> done=1 within 4 cycles of first fetch.
REQ-043 PC stepping forever, TIMEOUT=20 -> timeout=1, cycle_count=19, cpu_reset=1.
